// File: rtl/modexp_seq.sv
// modexp_seq: left-to-right square-and-multiply sequencer for an external modular
// multiplier. Issues accumulator-load and multiplier commands over a req/done handshake.
module modexp_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] exp,
  input  logic        mm_done,
  output logic        busy,
  output logic        done,
  output logic        acc_load,
  output logic        acc_one,
  output logic        mm_req,
  output logic        mm_op,
  output logic [4:0]  bit_idx
);

  typedef enum logic [3:0] {
    IDLE,
    LEN,
    LOAD,
    CHECK,
    SQR_REQ,
    SQR_WAIT,
    MUL_REQ,
    MUL_WAIT,
    DONE
  } state_t;

  state_t      state_reg;
  logic [31:0] exp_reg;
  logic [5:0]  nbits_reg;
  logic [4:0]  bit_idx_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        acc_load_reg;
  logic        acc_one_reg;
  logic        mm_req_reg;
  logic        mm_op_reg;

  // seen_above[i] is set when any exponent bit at position i or higher is set, so the
  // number of set flags equals the bit length of the exponent.
  logic [31:0] seen_above;
  logic [5:0]  nbits_next;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_seen_above
      assign seen_above[gi] = |exp_reg[31:gi];
    end
  endgenerate

  always_comb begin
    nbits_next = 6'd0;
    for (int i = 0; i < 32; i++) begin
      nbits_next = nbits_next + {5'd0, seen_above[i]};
    end
  end

  // Outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      exp_reg      <= 32'd0;
      nbits_reg    <= 6'd0;
      bit_idx_reg  <= 5'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      acc_load_reg <= 1'b0;
      acc_one_reg  <= 1'b0;
      mm_req_reg   <= 1'b0;
      mm_op_reg    <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      acc_load_reg <= 1'b0;
      acc_one_reg  <= 1'b0;
      mm_req_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            exp_reg   <= exp;
            busy_reg  <= 1'b1;
            state_reg <= LEN;
          end
        end
        LEN: begin
          nbits_reg <= nbits_next;
          if (exp_reg == 32'd0) begin
            done_reg    <= 1'b1;
            acc_one_reg <= 1'b1;
            state_reg   <= DONE;
          end else begin
            // nbits_next == 32 wraps to 0 in five bits, so the decrement lands on 31.
            bit_idx_reg  <= nbits_next[4:0] - 5'd1;
            acc_load_reg <= 1'b1;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          state_reg <= CHECK;
        end
        CHECK: begin
          if (bit_idx_reg == 5'd0) begin
            done_reg    <= 1'b1;
            acc_one_reg <= (nbits_reg == 6'd0);
            state_reg   <= DONE;
          end else begin
            bit_idx_reg <= bit_idx_reg - 5'd1;
            mm_req_reg  <= 1'b1;
            mm_op_reg   <= 1'b0;
            state_reg   <= SQR_REQ;
          end
        end
        SQR_REQ: begin
          state_reg <= SQR_WAIT;
        end
        SQR_WAIT: begin
          if (mm_done) begin
            if (exp_reg[bit_idx_reg]) begin
              mm_req_reg <= 1'b1;
              mm_op_reg  <= 1'b1;
              state_reg  <= MUL_REQ;
            end else begin
              state_reg <= CHECK;
            end
          end
        end
        MUL_REQ: begin
          state_reg <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mm_done) begin
            state_reg <= CHECK;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign acc_load = acc_load_reg;
  assign acc_one  = acc_one_reg;
  assign mm_req   = mm_req_reg;
  assign mm_op    = mm_op_reg;
  assign bit_idx  = bit_idx_reg;

endmodule

// File: tb/tb_modexp_seq.sv
// Self-checking bench for modexp_seq: directed vector table, hand-written corner
// sequences and randomized runs checked against a square-and-multiply schedule model.
module tb_modexp_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] exp;
  logic        mm_done;
  logic        busy;
  logic        done;
  logic        acc_load;
  logic        acc_one;
  logic        mm_req;
  logic        mm_op;
  logic [4:0]  bit_idx;

  always #5 clk = ~clk;

  modexp_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .exp      (exp),
    .mm_done  (mm_done),
    .busy     (busy),
    .done     (done),
    .acc_load (acc_load),
    .acc_one  (acc_one),
    .mm_req   (mm_req),
    .mm_op    (mm_op),
    .bit_idx  (bit_idx)
  );

  localparam int BUDGET = 3000;

  int checks = 0;
  int errors = 0;

  // Observations from the most recent run (op encoded as bit_idx*2 + mm_op).
  int got_ops[$];
  int req_cyc[$];
  int lat_sum;
  int got_dones;
  int got_done_cyc;
  int got_loads;
  int got_load_cyc;
  int got_one;
  int glitches;
  bit timed_out;

  typedef struct {
    logic [31:0] e;
    int          lat;
    int          done_cyc;
    int          n_sq;
    int          n_mul;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  function automatic int bit_len(input logic [31:0] e);
    int n = 0;
    for (int i = 0; i < 32; i++) if (e[i]) n = i + 1;
    return n;
  endfunction

  // Drives one exponentiation from start (cycle 0) until the cycle after done, acting
  // as the multiplier. fixed_lat = 0 picks a random 1..20 latency per op. noisy adds
  // stray mm_done, stray start and exp churn in cycles where the block must ignore them.
  task automatic run_one(input logic [31:0] e, input int fixed_lat, input bit noisy);
    int countdown = 0;
    int lat;
    bit hit;
    bit prev_hit = 1'b0;
    got_ops.delete();
    req_cyc.delete();
    lat_sum = 0;
    got_dones = 0;
    got_done_cyc = -1;
    got_loads = 0;
    got_load_cyc = -1;
    got_one = 0;
    glitches = 0;
    timed_out = 1'b1;
    @(negedge clk);
    start = 1'b1;
    exp = e;
    mm_done = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      mm_done = 1'b0;
      if (noisy) exp = $urandom;
      if (got_dones > 0 && cyc == got_done_cyc + 1) begin
        if (busy || done || mm_req || acc_load || acc_one) glitches++;
        timed_out = 1'b0;
        break;
      end
      if (!busy) glitches++;
      if (acc_load) begin
        got_loads++;
        got_load_cyc = cyc;
      end
      if (acc_one && done) got_one++;
      if (acc_one && !done) glitches++;
      if (done) begin
        got_dones++;
        got_done_cyc = cyc;
      end
      hit = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          mm_done = 1'b1;
          hit = 1'b1;
        end
      end
      if (mm_req) begin
        got_ops.push_back(int'(bit_idx) * 2 + int'(mm_op));
        req_cyc.push_back(cyc);
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(20, 1));
        lat_sum += lat;
        countdown = lat;
        if (noisy && $urandom_range(1, 0) == 1) mm_done = 1'b1;
      end else if (noisy && (prev_hit || cyc <= 3) && $urandom_range(1, 0) == 1) begin
        mm_done = 1'b1;
      end
      if (noisy && busy && !done && $urandom_range(3, 0) == 0) start = 1'b1;
      prev_hit = hit;
    end
    start = 1'b0;
    mm_done = 1'b0;
  endtask

  // Reference: for each exponent bit below the MSB, a square, then a multiply if the bit
  // is set. Latency: LEN, LOAD, first CHECK, then per op REQ + wait, per bit one CHECK,
  // then DONE.
  task automatic verify(input string tag, input logic [31:0] e, input int want_done);
    int n = bit_len(e);
    int model[$];
    int first_bad = -1;
    int want_cyc;
    for (int i = n - 2; i >= 0; i--) begin
      model.push_back(i * 2);
      if (e[i]) model.push_back(i * 2 + 1);
    end
    if (want_done >= 0) want_cyc = want_done;
    else if (e == 32'd0) want_cyc = 2;
    else want_cyc = 4 + model.size() + lat_sum + (n - 1);
    check({tag, ".timeout"}, int'(timed_out), 0);
    check({tag, ".op_count"}, got_ops.size(), model.size());
    for (int k = 0; k < model.size() && k < got_ops.size(); k++) begin
      if (first_bad < 0 && got_ops[k] != model[k]) first_bad = k;
    end
    check({tag, ".op_first_bad_index"}, first_bad, -1);
    check({tag, ".acc_load_count"}, got_loads, (e != 32'd0) ? 1 : 0);
    check({tag, ".acc_load_cycle"}, got_load_cyc, (e != 32'd0) ? 2 : -1);
    check({tag, ".done_count"}, got_dones, 1);
    check({tag, ".done_cycle"}, got_done_cyc, want_cyc);
    check({tag, ".acc_one"}, got_one, (e == 32'd0) ? 1 : 0);
    check({tag, ".busy_or_stray"}, glitches, 0);
  endtask

  function automatic int count_ops(input int op);
    int c = 0;
    foreach (got_ops[k]) if ((got_ops[k] % 2) == op) c++;
    return c;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int want_cyc[5] = '{4, 7, 9, 12, 14};
    int want_op[5]  = '{0, 0, 1, 0, 1};
    logic [31:0] e;

    tbl[0] = '{32'h0000000B, 1, 17, 3, 2};
    tbl[1] = '{32'h00000000, 1, 2, 0, 0};
    tbl[2] = '{32'h00000001, 1, 4, 0, 0};
    tbl[3] = '{32'h80000000, 1, 97, 31, 0};
    tbl[4] = '{32'hFFFFFFFF, 1, 159, 31, 31};
    tbl[5] = '{32'h00000005, 3, 18, 2, 1};
    tbl[6] = '{32'h00000010, 2, 20, 4, 0};

    rst = 1'b1;
    start = 1'b0;
    mm_done = 1'b0;
    exp = 32'd0;
    repeat (3) @(negedge clk);
    check("reset.outputs", int'({busy, done, acc_load, acc_one, mm_req, mm_op, bit_idx}), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle.outputs%0d", i),
            int'({busy, done, acc_load, acc_one, mm_req, mm_op, bit_idx}), 0);
      mm_done = (i == 2);
    end
    mm_done = 1'b0;

    run_one(32'h0000000B, 1, 1'b0);
    verify("e0b", 32'h0000000B, 17);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("e0b.req_cycle%0d", k), (k < req_cyc.size()) ? req_cyc[k] : -1, want_cyc[k]);
      check($sformatf("e0b.mm_op%0d", k), (k < got_ops.size()) ? got_ops[k] % 2 : -1, want_op[k]);
    end

    for (int i = 0; i < 7; i++) begin
      run_one(tbl[i].e, tbl[i].lat, 1'b0);
      verify($sformatf("tbl%0d", i), tbl[i].e, tbl[i].done_cyc);
      check($sformatf("tbl%0d.squares", i), count_ops(0), tbl[i].n_sq);
      check($sformatf("tbl%0d.multiplies", i), count_ops(1), tbl[i].n_mul);
    end

    // mm_done and exp churn while idle must not wake the block
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("idle_mm_done%0d", i), int'({busy, mm_req, done}), 0);
      mm_done = 1'b1;
      exp = $urandom;
    end
    mm_done = 1'b0;

    // Reset while a square is outstanding; the late mm_done must be ignored
    @(negedge clk);
    start = 1'b1;
    exp = 32'h0000000B;
    for (int c = 1; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mm_req) break;
    end
    check("rstmid.req_seen", int'(mm_req), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.outputs", int'({busy, done, acc_load, acc_one, mm_req, mm_op, bit_idx}), 0);
    mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rstmid.after%0d", i), int'({busy, done, mm_req, acc_load}), 0);
      @(negedge clk);
    end
    run_one(32'h00000005, 2, 1'b0);
    verify("rstmid.e5", 32'h00000005, 15);

    for (int r = 0; r < 25; r++) begin
      e = $urandom;
      e = e >> $urandom_range(31, 0);
      if ($urandom_range(9, 0) == 0) e = 32'd0;
      run_one(e, 0, 1'b1);
      verify($sformatf("rand%0d", r), e, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
